seq_detector_param: RTL
=======================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter DEFAULT_PATTERN, default 4'b1011 (N bits), giving the pattern loaded at reset; the first-received bit is the MSB.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the match-counter width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  qualifies w; a bit SHALL be consumed only in cycles where en=1.
REQ-007 w  input  1  serial data bit.
REQ-008 load  input  1  one-cycle strobe that replaces the active pattern with pat_in.
REQ-009 pat_in  input  N  new pattern, sampled when load=1.
REQ-010 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 z  output  1  registered match pulse.
REQ-012 count  output  CNT_W  saturating count of matches since reset or load.

Function
REQ-013 The block SHALL keep an (N-1)-bit history shift register, a fill counter (0..N-1) and an N-bit pattern register.
REQ-014 In each consumed cycle, {history, w} SHALL be compared with the pattern; a match SHALL count only when fill = N-1.
REQ-015 On a match, z SHALL be 1 for exactly the cycle after the edge that consumed the final bit (latency 1); otherwise z SHALL be 0.
REQ-016 z SHALL also be 0 in any cycle following an edge where en=0, load=1 or rst=1.
REQ-017 Non-match consumed cycle: the history SHALL shift in w, and fill SHALL increment, saturating at N-1.
REQ-018 Match with overlap=1: the history SHALL shift in w and fill SHALL stay at N-1, so overlapping occurrences are detected.
REQ-019 Match with overlap=0: history and fill SHALL clear to 0, so the next match needs N fresh bits.
REQ-020 When en=0, history, fill and count SHALL hold.
REQ-021 On load=1, the pattern SHALL become pat_in, history, fill and count SHALL clear, and w SHALL be ignored in that cycle, even if en=1.
REQ-022 overlap SHALL be sampled per cycle; a change takes effect on the next match.
REQ-023 count SHALL increment by 1 per match and hold at 2^CNT_W-1 without wrapping.
REQ-024 Priority SHALL be rst > load > en.

Reset
REQ-025 On rst=1 at a clock edge: z=0, count=0, history=0, fill=0, pattern=DEFAULT_PATTERN.
REQ-026 Reset asserted mid-sequence SHALL discard all partial-match progress; no z pulse may arise from bits received before reset.

Configuration
REQ-027 With macro SEQ_DET_COUNT_EN defined, the match counter SHALL be implemented as specified above.
REQ-028 Without SEQ_DET_COUNT_EN, no counter logic SHALL be synthesised, the count port SHALL remain and be driven constant 0, and z behaviour SHALL be unchanged.

Verification (N=4, pattern 1011, en=1 unless stated, SEQ_DET_COUNT_EN defined)
REQ-029 Overlap: overlap=1, w=1,0,1,1,0,1,1 -> z pulses after bits 4 and 7 only; count=2.
REQ-030 Non-overlap: overlap=0, same stream -> z pulses after bit 4 only; count=1.
REQ-031 Stall and reset: stream 1,0,1 with en=0 for 3 cycles, then w=1 -> one z pulse. Separately, stream 1,0,1, then rst, then w=1 -> no pulse, count=0.
REQ-032 Load mid-stream: after 1,0, load pat_in=0110 with w=1 and en=1 in the same cycle -> that bit is ignored; then 0,1,1,0 -> one z pulse; count=1.
REQ-033 Saturation: CNT_W=2, overlap=0, send 1011 five times -> five z pulses; count stops at 3.
REQ-034 Macro off: rerun the REQ-029 stream -> identical z pulses; count stays 0 throughout.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with runtime-loadable pattern and overlap control.
// Define SEQ_DET_COUNT_EN to build the saturating match counter; otherwise count is tied to 0.
module seq_detector_param #(
    parameter int             N               = 4,
    parameter logic [N-1:0]   DEFAULT_PATTERN = 4'b1011,
    parameter int             CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             w,
    input  logic             load,
    input  logic [N-1:0]     pat_in,
    input  logic             overlap,
    output logic             z,
    output logic [CNT_W-1:0] count
);

    localparam int             FW       = $clog2(N);
    localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);

    logic [N-2:0]  history;
    logic [FW-1:0] fill;
    logic [N-1:0]  pattern;
    logic [N-1:0]  window;
    logic          match;

    // The newest bit sits in the LSB, so the oldest bit lines up with the pattern MSB.
    always_comb begin
        window = {history, w};
        match  = (fill == FILL_MAX) && (window == pattern);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z       <= 1'b0;
            history <= '0;
            fill    <= '0;
            pattern <= DEFAULT_PATTERN;
        end else if (load) begin
            z       <= 1'b0;
            history <= '0;
            fill    <= '0;
            pattern <= pat_in;
        end else if (en) begin
            z <= match;
            if (match && !overlap) begin
                history <= '0;
                fill    <= '0;
            end else begin
                history <= window[N-2:0];
                if (fill != FILL_MAX) begin
                    fill <= fill + 1'b1;
                end
            end
        end else begin
            z <= 1'b0;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (en && match && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign count = cnt;
`else
    assign count = '0;
`endif

endmodule
